// File: rtl/hz_tick_ctrl_if.sv
// hz_tick_ctrl_if: config, sequence control and tick outputs of the Hz tick controller
interface hz_tick_ctrl_if #(
    parameter int DIV_W = 32,
    parameter int CNT_W = 16
);
    logic             cfg_we;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_count;
    logic             cfg_mode;
    logic             start;
    logic             stop;
    logic             tick;
    logic             outclk;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ticks_left;
    modport master (
        output cfg_we, cfg_div, cfg_count, cfg_mode, start, stop,
        input  tick, outclk, busy, done, ticks_left
    );
    modport slave (
        input  cfg_we, cfg_div, cfg_count, cfg_mode, start, stop,
        output tick, outclk, busy, done, ticks_left
    );
endinterface

// File: rtl/hz_tick_ctrl.sv
// hz_tick_ctrl: programmable tick enable and slow square wave, burst or continuous
module hz_tick_ctrl #(
    parameter int          DIV_W       = 32,
    parameter int          CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input logic          clk,
    input logic          reset,
    hz_tick_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]       state;
    logic [DIV_W-1:0] div_reg, phase, d_eff;
    logic [CNT_W-1:0] count_reg, n_eff, ticks_left;
    logic             mode_reg, m_eff, tick, outclk, done;
    // a same-edge config write is what the start uses
    assign d_eff = bus.cfg_we ? (bus.cfg_div < DIV_W'(2) ? DIV_W'(2) : bus.cfg_div) : div_reg;
    assign n_eff = bus.cfg_we ? bus.cfg_count : count_reg;
    assign m_eff = bus.cfg_we ? bus.cfg_mode : mode_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_reg    <= DIV_W'(DEFAULT_DIV);
            count_reg  <= CNT_W'(1);
            mode_reg   <= 1'b0;
            phase      <= '0;
            tick       <= 1'b0;
            outclk     <= 1'b0;
            done       <= 1'b0;
            ticks_left <= '0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    outclk <= 1'b0;
                    if (bus.cfg_we) begin
                        div_reg   <= d_eff;
                        count_reg <= n_eff;
                        mode_reg  <= m_eff;
                    end
                    if (bus.start && !bus.stop) begin
                        phase      <= d_eff - DIV_W'(1);
                        ticks_left <= n_eff;
                        state      <= (!m_eff && n_eff == '0) ? DONE : RUN;
                        done       <= !m_eff && n_eff == '0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state      <= IDLE;
                        outclk     <= 1'b0;
                        ticks_left <= '0;
                    end else if (!mode_reg && ticks_left == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (phase == '0) begin
                        phase  <= div_reg - DIV_W'(1);
                        tick   <= 1'b1;
                        outclk <= ~outclk;
                        if (!mode_reg) ticks_left <= ticks_left - CNT_W'(1);
                    end else begin
                        phase <= phase - DIV_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    outclk     <= 1'b0;
                    ticks_left <= '0;
                end
            endcase
        end
    end
    assign bus.tick       = tick;
    assign bus.outclk     = outclk;
    assign bus.busy       = state != IDLE;
    assign bus.done       = done;
    assign bus.ticks_left = ticks_left;
endmodule
